// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Shares one DEPTH-entry, 8-bit stack between NUM_REQ requesters. Requests are
//   granted round-robin and one stack operation is in flight at a time. The
//   arbiter pulses the stack's push or pop for one cycle, waits out the stack's
//   two-cycle registered latency, then returns pop data and error status to the
//   winning requester.
//
//   FSM: IDLE -> ISSUE -> WAIT1 -> WAIT2 -> RESP -> IDLE. Ops that are rejected
//   without touching the stack take the short path IDLE -> RESP. All outputs
//   are registered.
//
//   Optional feature macro: STACK_ARB_OCC_EN
//     Adds a local occupancy counter and the occupancy port. Pushes into a full
//     stack and pops from an empty one are then rejected without a stack pulse.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   req_push      in   [NUM_REQ]   push request per requester, held until its resp_valid
//   req_pop       in   [NUM_REQ]   pop request per requester, held until its resp_valid
//   req_data      in   [8*NUM_REQ] push data, requester i at [8*i+7:8*i]
//   resp_valid    out  [NUM_REQ]   one-hot completion pulse to the served requester
//   resp_data     out  [8]         popped byte, valid with resp_valid
//   resp_error    out  1           op failed (overflow, underflow or illegal)
//   stk_push      out  1           stack push strobe
//   stk_pop       out  1           stack pop strobe
//   stk_data_in   out  [8]         stack write data
//   stk_data_out  in   [8]         stack read data
//   stk_error     in   1           stack error flag
//   occupancy     out  [5]         entries held (STACK_ARB_OCC_EN only)

module stack_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_push,
    input  logic [NUM_REQ-1:0]   req_pop,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [7:0]           resp_data,
    output logic                 resp_error,
    output logic                 stk_push,
    output logic                 stk_pop,
    output logic [7:0]           stk_data_in,
    input  logic [7:0]           stk_data_out,
    input  logic                 stk_error
`ifdef STACK_ARB_OCC_EN
    ,
    output logic [4:0]           occupancy
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT1 = 3'd2,
        WAIT2 = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [IW-1:0]        rr, rr_d;
    logic [IW-1:0]        winner, winner_d;
    logic                 op_pop, op_pop_d;
    logic [NUM_REQ-1:0]   resp_valid_d;
    logic [7:0]           resp_data_d;
    logic                 resp_error_d;
    logic                 stk_push_d, stk_pop_d;
    logic [7:0]           stk_data_in_d;

    // Round-robin selection signals.
    logic [NUM_REQ-1:0]   active;
    logic [NUM_REQ-1:0]   rot;
    logic                 found;
    logic [IW-1:0]        off;
    logic [IW:0]          sum;
    logic [IW-1:0]        pick;
    logic                 sel_push, sel_pop;
    logic [7:0]           sel_data;
    logic                 reject;

`ifdef STACK_ARB_OCC_EN
    logic [4:0]           occ, occ_d;
`endif

    // Rotate the active vector so bit 0 is the requester at the rr pointer;
    // the lowest set bit of the rotated vector is the next winner.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        active = req_push | req_pop;
        rot    = NUM_REQ'({active, active} >> rr);
        found  = |active;
        off    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum  = {1'b0, rr} + {1'b0, off};
        pick = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);

        sel_push = 1'b0;
        sel_pop  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IW'(i)) begin
                sel_push = req_push[i];
                sel_pop  = req_pop[i];
                sel_data = req_data[8*i +: 8];
            end
        end

        // Ops answered with an error without reaching the stack.
        reject = sel_push & sel_pop;
`ifdef STACK_ARB_OCC_EN
        reject = reject | (sel_push & (occ == 5'(DEPTH))) | (sel_pop & (occ == 5'd0));
`endif
    end

    always_comb begin
        state_d       = state;
        rr_d          = rr;
        winner_d      = winner;
        op_pop_d      = op_pop;
        resp_valid_d  = '0;
        resp_data_d   = '0;
        resp_error_d  = 1'b0;
        stk_push_d    = 1'b0;
        stk_pop_d     = 1'b0;
        stk_data_in_d = '0;
`ifdef STACK_ARB_OCC_EN
        occ_d         = occ;
`endif

        unique case (state)
            IDLE: begin
                if (found) begin
                    winner_d = pick;
                    op_pop_d = sel_pop;
                    if (reject) begin
                        state_d      = RESP;
                        resp_valid_d = NUM_REQ'(1) << pick;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d       = ISSUE;
                        stk_push_d    = sel_push;
                        stk_pop_d     = sel_pop;
                        stk_data_in_d = sel_push ? sel_data : 8'h00;
                    end
                end
            end
            ISSUE: state_d = WAIT1;
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                // Stack results are valid in this cycle; capture them on the
                // transition into RESP.
                state_d      = RESP;
                resp_valid_d = NUM_REQ'(1) << winner;
                resp_error_d = stk_error;
                resp_data_d  = (op_pop && !stk_error) ? stk_data_out : 8'h00;
`ifdef STACK_ARB_OCC_EN
                if (!stk_error) occ_d = op_pop ? occ - 5'd1 : occ + 5'd1;
`endif
            end
            RESP: begin
                state_d = IDLE;
                rr_d    = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr          <= '0;
            winner      <= '0;
            op_pop      <= 1'b0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_error  <= 1'b0;
            stk_push    <= 1'b0;
            stk_pop     <= 1'b0;
            stk_data_in <= '0;
`ifdef STACK_ARB_OCC_EN
            occ         <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before this clock edge.
            state       <= state_d;
            rr          <= rr_d;
            winner      <= winner_d;
            op_pop      <= op_pop_d;
            resp_valid  <= resp_valid_d;
            resp_data   <= resp_data_d;
            resp_error  <= resp_error_d;
            stk_push    <= stk_push_d;
            stk_pop     <= stk_pop_d;
            stk_data_in <= stk_data_in_d;
`ifdef STACK_ARB_OCC_EN
            occ         <= occ_d;
`endif
        end
    end

`ifdef STACK_ARB_OCC_EN
    assign occupancy = occ;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter
//   Drives stack_arbiter with directed and random requests. A small stack with
//   two-cycle registered latency stands in for the real stack instance, and an
//   operation-level reference model (queue + round-robin rule) supplies the
//   expected winner, data, error and latency of every response.
//   Build with +define+STACK_ARB_OCC_EN to exercise the occupancy variant.

module tb_stack_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_push = '0;
    logic [N-1:0]   req_pop = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   resp_valid;
    logic [7:0]     resp_data;
    logic           resp_error;
    logic           stk_push, stk_pop;
    logic [7:0]     stk_data_in;
    logic [7:0]     stk_data_out;
    logic           stk_error;
`ifdef STACK_ARB_OCC_EN
    logic [4:0]     occupancy;
`endif

    int checks = 0;
    int errors = 0;

    stack_arbiter #(.NUM_REQ(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_push     (req_push),
        .req_pop      (req_pop),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_error   (resp_error),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_error    (stk_error)
`ifdef STACK_ARB_OCC_EN
        ,
        .occupancy    (occupancy)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- stack stand-in: op seen at edge k, result visible after edge k+1
    logic [7:0] env_mem [DEPTH];
    int         env_sp;
    logic [7:0] s1_data;
    logic       s1_err;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            env_sp       <= 0;
            s1_data      <= '0;
            s1_err       <= 1'b0;
            stk_data_out <= '0;
            stk_error    <= 1'b0;
        end else begin
            s1_data <= '0;
            s1_err  <= 1'b0;
            if (stk_push && stk_pop) begin
                s1_err <= 1'b1;
            end else if (stk_push) begin
                if (env_sp == DEPTH) s1_err <= 1'b1;
                else begin
                    env_mem[env_sp] <= stk_data_in;
                    env_sp          <= env_sp + 1;
                end
            end else if (stk_pop) begin
                if (env_sp == 0) s1_err <= 1'b1;
                else begin
                    s1_data <= env_mem[env_sp-1];
                    env_sp  <= env_sp - 1;
                end
            end
            stk_data_out <= s1_data;
            stk_error    <= s1_err;
        end
    end

    // ---------------- reference model
    logic [7:0] ref_q[$];
    int         ref_rr;

    function automatic int ref_pick(input logic [N-1:0] act);
        for (int k = 0; k < N; k++) begin
            if (act[(ref_rr + k) % N]) return (ref_rr + k) % N;
        end
        return -1;
    endfunction

    // Expected outcome of one op by requester w. lat counts cycles from the
    // IDLE cycle in which the request is seen to the resp_valid cycle.
    task automatic model_op(input int w, input logic pu, input logic po, input logic [7:0] din,
                            output int lat, output logic [7:0] d, output logic e,
                            output int npu, output int npo);
        d   = '0;
        e   = 1'b0;
        lat = 4;
        npu = int'(pu && !po);
        npo = int'(po && !pu);
        if (pu && po) begin
            e   = 1'b1;
            lat = 1;
        end else if (pu) begin
            if (ref_q.size() >= DEPTH) begin
                e = 1'b1;
`ifdef STACK_ARB_OCC_EN
                lat = 1;
                npu = 0;
`endif
            end else ref_q.push_back(din);
        end else begin
            if (ref_q.size() == 0) begin
                e = 1'b1;
`ifdef STACK_ARB_OCC_EN
                lat = 1;
                npo = 0;
`endif
            end else d = ref_q.pop_back();
        end
        ref_rr = (w + 1) % N;
    endtask

    // Waits (bounded) for the next resp_valid and reports what was seen.
    // lat = -1 means no response inside the budget.
    task automatic wait_resp(output int lat, output logic [N-1:0] v, output logic [7:0] d,
                             output logic e, output int npu, output int npo,
                             output int op_at, output logic [7:0] din);
        lat = -1; v = '0; d = '0; e = 1'b0; npu = 0; npo = 0; op_at = -1; din = '0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (stk_push) begin npu++; op_at = n; din = stk_data_in; end
            if (stk_pop)  begin npo++; op_at = n; din = stk_data_in; end
            if (resp_valid != '0) begin
                lat = n; v = resp_valid; d = resp_data; e = resp_error;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        req_push = '0; req_pop = '0; req_data = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        ref_q.delete();
        ref_rr = 0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
        checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset resp_data: got %h want 0", resp_data); end
        checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset resp_error: got %b want 0", resp_error); end
        checks++; if ({stk_push, stk_pop, stk_data_in} !== 10'd0) begin errors++; $display("FAIL reset stk: got %b%b %h want 0", stk_push, stk_pop, stk_data_in); end
`ifdef STACK_ARB_OCC_EN
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset occupancy: got %0d want 0", occupancy); end
`endif
        reset_n = 1'b1;
        ref_q.delete();
        ref_rr = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({resp_valid, stk_push, stk_pop} !== '0) begin errors++; $display("FAIL idle quiet: got %b %b %b want 0", resp_valid, stk_push, stk_pop); end
    endtask

    task automatic test_push_pop();
        int lat, npu, npo, op_at;
        logic [N-1:0] v;
        logic [7:0] d, din;
        logic e;
        apply_reset();
        req_push[0] = 1'b1; req_data[7:0] = 8'hA5;
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push = '0;
        checks++; if (lat !== 4) begin errors++; $display("FAIL push latency: got %0d want 4", lat); end
        checks++; if (v !== 4'b0001) begin errors++; $display("FAIL push resp_valid: got %b want 0001", v); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL push resp_error: got %b want 0", e); end
        checks++; if (npu !== 1 || npo !== 0 || op_at !== 1) begin errors++; $display("FAIL push strobe: got push=%0d pop=%0d at=%0d want 1 0 1", npu, npo, op_at); end
        checks++; if (din !== 8'hA5) begin errors++; $display("FAIL push stk_data_in: got %h want a5", din); end
        @(posedge clk); #1;
        checks++; if ({resp_valid, resp_data, resp_error} !== '0) begin errors++; $display("FAIL idle after resp: got %b %h %b want 0", resp_valid, resp_data, resp_error); end
        req_pop[0] = 1'b1;
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_pop = '0;
        checks++; if (lat !== 4 || v !== 4'b0001) begin errors++; $display("FAIL pop resp: got lat=%0d v=%b want 4 0001", lat, v); end
        checks++; if (d !== 8'hA5 || e !== 1'b0) begin errors++; $display("FAIL pop data: got %h err=%b want a5 0", d, e); end
        checks++; if (npo !== 1 || npu !== 0 || din !== 8'h00) begin errors++; $display("FAIL pop strobe: got pop=%0d push=%0d din=%h want 1 0 00", npo, npu, din); end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int lat, npu, npo, op_at, w, xl, xpu, xpo;
        logic [N-1:0] v;
        logic [7:0] d, din, xd;
        logic e, xe;
        apply_reset();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
        req_push = '1;
        for (int k = 0; k < 5; k++) begin
            w = ref_pick(req_push | req_pop);
            model_op(w, 1'b1, 1'b0, req_data[8*w +: 8], xl, xd, xe, xpu, xpo);
            wait_resp(lat, v, d, e, npu, npo, op_at, din);
            checks++; if (v !== N'(1 << (k % N))) begin errors++; $display("FAIL rr order k=%0d: got %b want %b", k, v, N'(1 << (k % N))); end
            checks++; if (lat !== ((k == 0) ? xl : xl + 1)) begin errors++; $display("FAIL rr spacing k=%0d: got %0d want %0d", k, lat, (k == 0) ? xl : xl + 1); end
            checks++; if (e !== xe || din !== req_data[8*w +: 8]) begin errors++; $display("FAIL rr push k=%0d: got err=%b din=%h want %b %h", k, e, din, xe, req_data[8*w +: 8]); end
        end
        req_push = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            req_pop[3] = 1'b1;
            model_op(3, 1'b0, 1'b1, 8'h00, xl, xd, xe, xpu, xpo);
            wait_resp(lat, v, d, e, npu, npo, op_at, din);
            req_pop = '0;
            checks++; if (d !== xd || e !== xe || v !== 4'b1000) begin errors++; $display("FAIL rr lifo k=%0d: got %h err=%b v=%b want %h %b 1000", k, d, e, v, xd, xe); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow_underflow();
        int lat, npu, npo, op_at, w, xl, xpu, xpo;
        logic [N-1:0] v;
        logic [7:0] d, din, xd, dat;
        logic e, xe, is_push;
        apply_reset();
        for (int k = 0; k < 2*DEPTH + 2; k++) begin
            w = $urandom_range(0, N-1);
            is_push = (k <= DEPTH);
            dat = 8'($urandom);
            req_data[8*w +: 8] = dat;
            req_push[w] = is_push;
            req_pop[w]  = !is_push;
            model_op(w, is_push, !is_push, dat, xl, xd, xe, xpu, xpo);
            wait_resp(lat, v, d, e, npu, npo, op_at, din);
            req_push = '0; req_pop = '0;
            checks++;
            if (lat !== xl || v !== N'(1 << w) || d !== xd || e !== xe || npu !== xpu || npo !== xpo) begin
                errors++;
                $display("FAIL boundary op %0d: got lat=%0d v=%b d=%h e=%b push=%0d pop=%0d want %0d %b %h %b %0d %0d",
                         k, lat, v, d, e, npu, npo, xl, N'(1 << w), xd, xe, xpu, xpo);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        int lat, npu, npo, op_at;
        logic [N-1:0] v;
        logic [7:0] d, din;
        logic e;
        apply_reset();
        req_push[2] = 1'b1; req_pop[2] = 1'b1; req_data[23:16] = 8'($urandom);
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push = '0; req_pop = '0;
        checks++; if (lat !== 1 || v !== 4'b0100) begin errors++; $display("FAIL illegal resp: got lat=%0d v=%b want 1 0100", lat, v); end
        checks++; if (e !== 1'b1 || d !== 8'h00) begin errors++; $display("FAIL illegal status: got err=%b d=%h want 1 00", e, d); end
        checks++; if (npu !== 0 || npo !== 0) begin errors++; $display("FAIL illegal strobe: got push=%0d pop=%0d want 0 0", npu, npo); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int lat, npu, npo, op_at, xl, xpu, xpo;
        logic [N-1:0] v;
        logic [7:0] d, din, xd;
        logic e, xe;
        apply_reset();
        // Serve requester 1 so the rr pointer moves to 2.
        req_push[1] = 1'b1; req_data[15:8] = 8'h3C;
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push = '0;
        @(posedge clk); #1;
        req_push[3] = 1'b1; req_data[31:24] = 8'h77;
        @(posedge clk); #1;
        checks++; if (stk_push !== 1'b1 || stk_data_in !== 8'h77) begin errors++; $display("FAIL midop issue: got %b %h want 1 77", stk_push, stk_data_in); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({resp_valid, resp_data, resp_error, stk_push, stk_pop, stk_data_in} !== '0) begin errors++; $display("FAIL midop async clear: got %b %h %b %b %b %h want 0", resp_valid, resp_data, resp_error, stk_push, stk_pop, stk_data_in); end
        req_push = 4'b1010; req_data[15:8] = 8'hC3;
        @(posedge clk); #1;
        checks++; if ({resp_valid, stk_push, stk_pop} !== '0) begin errors++; $display("FAIL midop held reset: got %b %b %b want 0", resp_valid, stk_push, stk_pop); end
        reset_n = 1'b1;
        ref_q.delete();
        ref_rr = 0;
        model_op(1, 1'b1, 1'b0, 8'hC3, xl, xd, xe, xpu, xpo);
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push[1] = 1'b0;
        checks++; if (lat !== xl || v !== 4'b0010) begin errors++; $display("FAIL resume rr: got lat=%0d v=%b want %0d 0010", lat, v, xl); end
        model_op(3, 1'b1, 1'b0, 8'h77, xl, xd, xe, xpu, xpo);
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push = '0;
        checks++; if (lat !== xl + 1 || v !== 4'b1000 || e !== xe) begin errors++; $display("FAIL resume next: got lat=%0d v=%b e=%b want %0d 1000 %b", lat, v, e, xl + 1, xe); end
        @(posedge clk); #1;
    endtask

`ifdef STACK_ARB_OCC_EN
    task automatic test_occupancy();
        int lat, npu, npo, op_at, xl, xpu, xpo;
        logic [N-1:0] v;
        logic [7:0] d, din, xd;
        logic e, xe;
        apply_reset();
        req_pop[0] = 1'b1;
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_pop = '0;
        checks++; if (lat !== 1 || e !== 1'b1 || npo !== 0) begin errors++; $display("FAIL occ empty pop: got lat=%0d e=%b pop=%0d want 1 1 0", lat, e, npo); end
        @(posedge clk); #1;
        checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL occ after reject: got %0d want 0", occupancy); end
        for (int k = 0; k < DEPTH; k++) begin
            req_push[1] = 1'b1; req_data[15:8] = 8'($urandom);
            model_op(1, 1'b1, 1'b0, req_data[15:8], xl, xd, xe, xpu, xpo);
            wait_resp(lat, v, d, e, npu, npo, op_at, din);
            req_push = '0;
            @(posedge clk); #1;
        end
        checks++; if (occupancy !== 5'(ref_q.size())) begin errors++; $display("FAIL occ full: got %0d want %0d", occupancy, ref_q.size()); end
        req_push[2] = 1'b1;
        wait_resp(lat, v, d, e, npu, npo, op_at, din);
        req_push = '0;
        checks++; if (lat !== 1 || e !== 1'b1 || npu !== 0) begin errors++; $display("FAIL occ full push: got lat=%0d e=%b push=%0d want 1 1 0", lat, e, npu); end
        @(posedge clk); #1;
    endtask
`endif

    task automatic spawn(input int i);
        int r;
        r = $urandom_range(0, 19);
        req_data[8*i +: 8] = 8'($urandom);
        req_push[i] = (r < 9) || (r >= 18);
        req_pop[i]  = (r >= 9);
    endtask

    task automatic test_random();
        int lat, npu, npo, op_at, w, xl, xpu, xpo, extra;
        logic [N-1:0] v;
        logic [7:0] d, din, xd;
        logic e, xe;
        apply_reset();
        spawn($urandom_range(0, N-1));
        extra = 0;
        for (int it = 0; it < 80; it++) begin
            w = ref_pick(req_push | req_pop);
            model_op(w, req_push[w], req_pop[w], req_data[8*w +: 8], xl, xd, xe, xpu, xpo);
            wait_resp(lat, v, d, e, npu, npo, op_at, din);
            checks++;
            if (lat !== xl + extra || v !== N'(1 << w) || d !== xd || e !== xe || npu !== xpu || npo !== xpo) begin
                errors++;
                $display("FAIL random op %0d: got lat=%0d v=%b d=%h e=%b push=%0d pop=%0d want %0d %b %h %b %0d %0d",
                         it, lat, v, d, e, npu, npo, xl + extra, N'(1 << w), xd, xe, xpu, xpo);
            end
            req_push[w] = 1'b0; req_pop[w] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!req_push[i] && !req_pop[i] && $urandom_range(0, 2) == 0) spawn(i);
            end
            if ((req_push | req_pop) == '0) spawn($urandom_range(0, N-1));
            extra = 1;
        end
        req_push = '0; req_pop = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_push_pop();
        test_round_robin();
        test_overflow_underflow();
        test_illegal();
        test_reset_midop();
`ifdef STACK_ARB_OCC_EN
        test_occupancy();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
